// File: rtl/clock_divider_scheduler.sv
// rtl/clock_divider_scheduler.sv - multi-channel programmable clock divider sharing one comparator

// Shared 32-bit magnitude comparator: q=1 when a<=b
module mag_compare (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        q
);
    assign q = (a <= b);
endmodule

module clock_divider_scheduler #(
    parameter int          NCH           = 4,
    parameter logic [31:0] DEFAULT_LIMIT = 32'd0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH)-1:0] cfg_chan,
    input  logic [31:0]            cfg_limit,
    input  logic                   cfg_en,
    output logic [NCH-1:0]         clk_out,
    output logic [NCH-1:0]         tick,
    output logic [$clog2(NCH)-1:0] slot
);
    localparam int SW = $clog2(NCH);

    logic [31:0]   count [NCH];
    logic [31:0]   limit [NCH];
    logic [NCH-1:0] en;

    logic          pend_valid;
    logic [SW-1:0] pend_chan;
    logic [31:0]   pend_limit;
    logic          pend_en;

    logic          terminal;

    // Single comparator instance, time-multiplexed by the slot pointer
    mag_compare u_cmp (
        .a (limit[slot]),
        .b (count[slot]),
        .q (terminal)
    );

    // Slot scheduler, per-channel service and config handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            slot       <= '0;
            en         <= '0;
            clk_out    <= '0;
            tick       <= '0;
            cfg_ready  <= 1'b1;
            pend_valid <= 1'b0;
            pend_chan  <= '0;
            pend_limit <= '0;
            pend_en    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                count[i] <= '0;
                limit[i] <= DEFAULT_LIMIT;
            end
        end else begin
            // NCH is a power of two, so the natural wrap of slot is NCH-1 -> 0
            slot <= slot + SW'(1);
            tick <= '0;

            // A pending config for this slot wins over counting; the compare
            // result is stale for the new limit and is ignored this visit
            if (pend_valid && (pend_chan == slot)) begin
                limit[slot]   <= pend_limit;
                en[slot]      <= pend_en;
                count[slot]   <= '0;
                clk_out[slot] <= 1'b0;
                pend_valid    <= 1'b0;
                cfg_ready     <= 1'b1;
            end else if (en[slot]) begin
                if (terminal) begin
                    count[slot]   <= '0;
                    clk_out[slot] <= ~clk_out[slot];
                    tick[slot]    <= 1'b1;
                end else begin
                    count[slot] <= count[slot] + 32'd1;
                end
            end

            // Capture a new request; cfg_ready is low while one is pending,
            // so capture and apply never coincide
            if (cfg_valid && cfg_ready) begin
                pend_valid <= 1'b1;
                pend_chan  <= cfg_chan;
                pend_limit <= cfg_limit;
                pend_en    <= cfg_en;
                cfg_ready  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clock_divider_scheduler.sv
// tb/tb_clock_divider_scheduler.sv - self-checking bench for clock_divider_scheduler

module tb_clock_divider_scheduler;
    localparam int NCH = 4;
    localparam int SW  = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [SW-1:0]  cfg_chan;
    logic [31:0]    cfg_limit;
    logic           cfg_en;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [SW-1:0]  slot;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    clock_divider_scheduler #(.NCH(NCH), .DEFAULT_LIMIT(32'd0)) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_limit (cfg_limit),
        .cfg_en    (cfg_en),
        .clk_out   (clk_out),
        .tick      (tick),
        .slot      (slot)
    );

    // Reference model state
    logic [31:0]    m_cnt [NCH];
    logic [31:0]    m_lim [NCH];
    logic [NCH-1:0] m_en   = '0;
    logic [NCH-1:0] m_clk  = '0;
    logic [NCH-1:0] m_tick = '0;
    int             m_slot = 0;
    logic           m_rdy  = 1'b1;
    logic           m_pv   = 1'b0;
    int             m_pc   = 0;
    logic [31:0]    m_pl   = '0;
    logic           m_pe   = 1'b0;

    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tk;
        logic [SW-1:0]  sl;
        logic           rdy;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven
    task automatic model_step();
        int   s;
        logic acc;
        if (reset) begin
            m_slot = 0;
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 0;
                m_lim[c] = 0;
            end
            m_en = '0; m_clk = '0; m_tick = '0;
            m_rdy = 1'b1; m_pv = 1'b0;
        end else begin
            s      = m_slot;
            acc    = cfg_valid && m_rdy;
            m_tick = '0;
            if (m_pv && (m_pc == s)) begin
                m_lim[s] = m_pl;
                m_en[s]  = m_pe;
                m_cnt[s] = 0;
                m_clk[s] = 1'b0;
                m_pv     = 1'b0;
                m_rdy    = 1'b1;
            end else if (m_en[s]) begin
                if (m_lim[s] <= m_cnt[s]) begin
                    m_cnt[s]  = 0;
                    m_clk[s]  = ~m_clk[s];
                    m_tick[s] = 1'b1;
                end else begin
                    m_cnt[s] = m_cnt[s] + 1;
                end
            end
            if (acc) begin
                m_pv  = 1'b1;
                m_pc  = int'(cfg_chan);
                m_pl  = cfg_limit;
                m_pe  = cfg_en;
                m_rdy = 1'b0;
            end
            m_slot = (m_slot + 1) % NCH;
        end
    endtask

    // One clock: push expectation, let the edge pass, pop and compare
    task automatic cycle();
        exp_t e;
        model_step();
        e.clk = m_clk; e.tk = m_tick; e.sl = SW'(m_slot); e.rdy = m_rdy;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("clk_out", 32'(clk_out), 32'(e.clk));
        check("tick", 32'(tick), 32'(e.tk));
        check("slot", 32'(slot), 32'(e.sl));
        check("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
        check("tick_onehot", 32'($countones(tick) <= 1), 32'd1);
    endtask

    task automatic do_cfg(input int ch, input int lim, input logic en_v);
        logic hs;
        int   n;
        n = 0;
        cfg_valid = 1'b1; cfg_chan = SW'(ch); cfg_limit = lim; cfg_en = en_v;
        do begin
            hs = cfg_ready;
            cycle();
            n++;
        end while (!hs && n < 20);
        cfg_valid = 1'b0;
        check("cfg_accept", 32'(hs), 32'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        check("ready_timeout", 32'(cfg_ready), 32'd1);
    endtask

    task automatic run_until_toggle(input int ch, input int budget, output int n);
        logic prev;
        prev = clk_out[ch];
        n = 0;
        while (n < budget) begin
            cycle();
            n++;
            if (clk_out[ch] !== prev) break;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_limit = '0; cfg_en = 1'b0;

        // Reset held two cycles
        cycle();
        cycle();
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_clk", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("slot_seq", 32'(slot), 32'((i + 1) % NCH));
        end

        // Single channel, limit=1: half period 8
        do_cfg(0, 1, 1'b1);
        run_until_toggle(0, 40, n);
        run_until_toggle(0, 40, n);
        check("ch0_half_period", n, 32'd8);
        check("ch0_tick_hi", 32'(tick[0]), 32'd1);
        cycle();
        check("ch0_tick_lo", 32'(tick[0]), 32'd0);

        // limit=0 on ch2, limit=3 on ch3
        do_cfg(2, 0, 1'b1);
        do_cfg(3, 3, 1'b1);
        run_until_toggle(2, 40, n);
        run_until_toggle(2, 40, n);
        check("ch2_half_period", n, 32'd4);
        run_until_toggle(3, 100, n);
        run_until_toggle(3, 100, n);
        check("ch3_half_period", n, 32'd16);

        // Handshake: second request held during the low window
        wait_ready(n);
        cfg_valid = 1'b1; cfg_chan = SW'(1); cfg_limit = 32'd7; cfg_en = 1'b1;
        cycle();
        check("hs_drop", 32'(cfg_ready), 32'd0);
        cfg_limit = 32'd2;
        n = 0;
        while (cfg_ready !== 1'b1 && n < 10) begin
            cycle();
            n++;
        end
        check("hs_rise_window", 32'(n >= 1 && n <= NCH), 32'd1);
        cycle();
        cfg_valid = 1'b0;
        check("hs_second_drop", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 40; i++) cycle();

        // Reconfigure a running channel: limit 5 -> 2
        do_cfg(0, 5, 1'b1);
        for (int i = 0; i < 60; i++) cycle();
        do_cfg(0, 2, 1'b1);
        wait_ready(n);
        check("reconf_clk0", 32'(clk_out[0]), 32'd0);
        run_until_toggle(0, 60, n);
        check("reconf_first_half", n, 32'd12);
        run_until_toggle(0, 60, n);
        check("reconf_half_period", n, 32'd12);

        // Disable ch1
        do_cfg(1, 0, 1'b0);
        wait_ready(n);
        for (int i = 0; i < 40; i++) begin
            cycle();
            check("dis_clk1", 32'(clk_out[1]), 32'd0);
            check("dis_tick1", 32'(tick[1]), 32'd0);
        end

        // Reset while a config is pending
        wait_ready(n);
        cfg_valid = 1'b1; cfg_chan = SW'(3); cfg_limit = 32'd9; cfg_en = 1'b1;
        cycle();
        cfg_valid = 1'b0;
        check("pend_ready_lo", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        cycle();
        check("mid_rst_ready", 32'(cfg_ready), 32'd1);
        check("mid_rst_clk", 32'(clk_out), 32'd0);
        check("mid_rst_slot", 32'(slot), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("post_rst_idle", 32'(clk_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
